serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Bit-serial WIDTH-bit adder controller. It sequences one full-adder slice, built from two half_adder instances plus an OR gate, over WIDTH cycles using a carry flip-flop and operand shift registers.
- Start/ready/done handshake toward the requester.
- Area-saving alternative to a parallel ripple adder; sits between a requesting control unit and the shared add datapath.

Parameters:
- WIDTH, 8, operand and result width in bits; legal values are WIDTH >= 1.
- CW, $clog2(WIDTH)+1, bit-counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; accepted only when start and ready are both high at a rising edge
- a  input  WIDTH  operand A; sampled only at the accept edge
- b  input  WIDTH  operand B; sampled only at the accept edge
- ready  output  1  high in IDLE only
- busy  output  1  high in RUN only
- done  output  1  one-cycle pulse; sum and cout are valid
- sum  output  WIDTH  result (a+b) mod 2^WIDTH; held until the next accept
- cout  output  1  carry out of bit WIDTH-1; held with sum

Behaviour:
- Reset (async, any state): state=IDLE, ready=1, busy=0, done=0, sum=0, cout=0, carry=0, count=0, shift registers=0. No done pulse is produced for an aborted operation.
- States: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - On start at edge E0: load a and b into shift registers, clear carry, count=0, clear sum, go to RUN.
  - start while not in IDLE is ignored, and operands are not sampled.
- RUN (edges E1..EWIDTH, one bit per edge, LSB first):
  - s1 = a0 ^ b0, c1 = a0 & b0 (half adder 1).
  - s = s1 ^ carry, c2 = s1 & carry (half adder 2).
  - carry <= c1 | c2.
  - Sum register shifts right with s inserted at the MSB; operand registers shift right; count++.
  - At the edge where count == WIDTH-1 is processed: cout <= c1 | c2, go to DONE.
- DONE:
  - done=1 and ready=0 for exactly one cycle; the next edge returns to IDLE.
  - done is therefore high in the cycle following edge EWIDTH, i.e. WIDTH edges after the accept edge.
  - Minimum throughput is one add per WIDTH+2 cycles.
- Result stability:
  - sum and cout change only during RUN.
  - After done, both hold their values through IDLE until the next accept edge clears sum.
- WIDTH=1: one RUN edge. The result equals a single half adder: sum = a^b, cout = a&b.
- Outputs are registered or decoded from state only; there is no combinational path from start, a or b to any output.
- Wrap-around: overflow beyond WIDTH bits appears only in cout; sum wraps mod 2^WIDTH.

Test Plan:
- WIDTH=1, start with (a,b) = 00, 01, 10, 11 -> (sum,cout) = 00, 10, 10, 01 respectively; done one edge after each RUN edge; ready low for 2 cycles per add.
- WIDTH=8, a=8'hFF, b=8'h01 -> sum=8'h00, cout=1; done high in the cycle after the 8th edge following accept, for exactly one cycle; busy high for 8 cycles.
- WIDTH=8, a=8'h5A, b=8'hA5 -> sum=8'hFF, cout=0. Then a=8'h80, b=8'h80 -> sum=8'h00, cout=1.
- WIDTH=8, accept a=8'h0F, b=8'h01; then hold start=1 with a=8'hFF, b=8'hFF during RUN -> second request ignored; result sum=8'h10, cout=0; a new accept occurs only once back in IDLE.
- WIDTH=8, assert rst at the 4th RUN cycle (asynchronously, mid-cycle) -> all outputs immediately reset values (ready=1, sum=0); no done pulse follows. A fresh add 8'h03+8'h04 then gives sum=8'h07.
- Back-to-back: keep start=1 continuously with a=8'h01, b=8'h01 -> accepts on every IDLE cycle; done pulses every WIDTH+2 = 10 cycles, each with sum=8'h02, cout=0.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder. One full-adder slice (two half adders plus an OR)
// is reused over WIDTH cycles, LSB first, with a carry flip-flop between bits.

module half_adder (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);
   assign s = a ^ b;
   assign c = a & b;
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] sum_r;
   logic [WIDTH-1:0] sum_shift;
   logic             cout_r;
   logic             carry;
   logic [CW-1:0]    count;
   logic             s1;
   logic             c1;
   logic             s;
   logic             c2;
   logic             carry_next;
   logic             last_bit;

   half_adder ha1 (.a(a_sr[0]), .b(b_sr[0]), .s(s1), .c(c1));
   half_adder ha2 (.a(s1),      .b(carry),   .s(s),  .c(c2));

   assign carry_next = c1 | c2;
   assign last_bit   = (count == CW'(WIDTH - 1));

   // The new sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
   generate
      if (WIDTH == 1) begin : g_narrow
         assign sum_shift = s;
      end else begin : g_wide
         assign sum_shift = {s, sum_r[WIDTH-1:1]};
      end
   endgenerate

   // Next-state logic; every request outside IDLE is simply not looked at.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (last_bit) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register and serial datapath; sum/cout only move during RUN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         a_sr   <= '0;
         b_sr   <= '0;
         sum_r  <= '0;
         cout_r <= 1'b0;
         carry  <= 1'b0;
         count  <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr  <= a;
                  b_sr  <= b;
                  sum_r <= '0;
                  carry <= 1'b0;
                  count <= '0;
               end
            end
            RUN: begin
               a_sr  <= a_sr >> 1;
               b_sr  <= b_sr >> 1;
               sum_r <= sum_shift;
               carry <= carry_next;
               count <= count + CW'(1);
               if (last_bit) cout_r <= carry_next;
            end
            default: begin
            end
         endcase
      end
   end

   assign ready = (state == IDLE);
   assign busy  = (state == RUN);
   assign done  = (state == DONE);
   assign sum   = sum_r;
   assign cout  = cout_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: a WIDTH=1 and a WIDTH=8 instance share
// clock and reset; expected sums and handshake timing are hand-computed.

module tb_serial_add_ctrl;

   logic       clk;
   logic       rst;
   logic       start1, start8;
   logic [0:0] a1, b1, sum1;
   logic [7:0] a8, b8, sum8;
   logic       ready1, busy1, done1, cout1;
   logic       ready8, busy8, done8, cout8;
   int         total;
   int         bad;

   serial_add_ctrl #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
      .ready(ready1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
   );

   serial_add_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
      .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // WIDTH=1: done must appear one edge after the single RUN edge.
   task automatic applyStimulus1(input logic av, input logic bv, input logic es, input logic ec);
      @(negedge clk);
      a1 = av; b1 = bv; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      checkOutput("w1_busy", 32'(busy1), 32'd1);
      checkOutput("w1_ready_run", 32'(ready1), 32'd0);
      @(negedge clk);
      checkOutput("w1_done", 32'(done1), 32'd1);
      checkOutput("w1_ready_done", 32'(ready1), 32'd0);
      checkOutput("w1_sum", 32'(sum1), 32'(es));
      checkOutput("w1_cout", 32'(ec), 32'(cout1));
      @(negedge clk);
      checkOutput("w1_ready_idle", 32'(ready1), 32'd1);
      checkOutput("w1_done_low", 32'(done1), 32'd0);
   endtask

   // WIDTH=8 add; optionally holds a competing request during RUN.
   task automatic applyStimulus8(input logic [7:0] av, input logic [7:0] bv,
                                 input logic [7:0] es, input logic ec, input bit hold);
      int cycles;
      int busyCnt;
      @(negedge clk);
      a8 = av; b8 = bv; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      if (hold) begin
         a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
      end
      cycles = 0;
      busyCnt = 0;
      while (!done8 && cycles < 20) begin
         if (busy8) busyCnt++;
         cycles++;
         @(negedge clk);
      end
      start8 = 1'b0;
      checkOutput("w8_latency", 32'(cycles), 32'd8);
      checkOutput("w8_busy_cycles", 32'(busyCnt), 32'd8);
      checkOutput("w8_sum", 32'(sum8), 32'(es));
      checkOutput("w8_cout", 32'(cout8), 32'(ec));
      checkOutput("w8_ready_done", 32'(ready8), 32'd0);
      @(negedge clk);
      checkOutput("w8_done_pulse", 32'(done8), 32'd0);
      checkOutput("w8_ready_idle", 32'(ready8), 32'd1);
      checkOutput("w8_sum_held", 32'(sum8), 32'(es));
      checkOutput("w8_cout_held", 32'(cout8), 32'(ec));
   endtask

   initial begin
      int prevIdx;
      int pulses;
      int sawDone;
      total = 0; bad = 0;
      start1 = 1'b0; a1 = '0; b1 = '0;
      start8 = 1'b0; a8 = '0; b8 = '0;
      rst = 1'b1;
      #12;
      checkOutput("rst_ready8", 32'(ready8), 32'd1);
      checkOutput("rst_busy8", 32'(busy8), 32'd0);
      checkOutput("rst_done8", 32'(done8), 32'd0);
      checkOutput("rst_sum8", 32'(sum8), 32'd0);
      checkOutput("rst_cout8", 32'(cout8), 32'd0);
      checkOutput("rst_ready1", 32'(ready1), 32'd1);
      @(negedge clk);
      rst = 1'b0;

      applyStimulus1(1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus1(1'b0, 1'b1, 1'b1, 1'b0);
      applyStimulus1(1'b1, 1'b0, 1'b1, 1'b0);
      applyStimulus1(1'b1, 1'b1, 1'b0, 1'b1);

      applyStimulus8(8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
      applyStimulus8(8'h5A, 8'hA5, 8'hFF, 1'b0, 1'b0);
      applyStimulus8(8'h80, 8'h80, 8'h00, 1'b1, 1'b0);
      applyStimulus8(8'h0F, 8'h01, 8'h10, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("ignored_req_idle", 32'(ready8), 32'd1);

      // Abort mid-run: 33+11 has partial sum 8'h80 after three RUN edges.
      @(negedge clk);
      a8 = 8'h33; b8 = 8'h11; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("abort_partial", 32'(sum8), 32'h80);
      #2 rst = 1'b1;
      #1;
      checkOutput("abort_ready", 32'(ready8), 32'd1);
      checkOutput("abort_busy", 32'(busy8), 32'd0);
      checkOutput("abort_sum", 32'(sum8), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      sawDone = 0;
      repeat (12) begin
         @(negedge clk);
         if (done8) sawDone = 1;
      end
      checkOutput("abort_no_done", 32'(sawDone), 32'd0);
      applyStimulus8(8'h03, 8'h04, 8'h07, 1'b0, 1'b0);

      // Back-to-back requests: one done every WIDTH+2 cycles.
      @(negedge clk);
      a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
      prevIdx = -1;
      pulses = 0;
      for (int i = 0; i < 45; i++) begin
         @(negedge clk);
         if (done8) begin
            checkOutput("b2b_sum", 32'(sum8), 32'h02);
            checkOutput("b2b_cout", 32'(cout8), 32'd0);
            if (prevIdx >= 0) checkOutput("b2b_period", 32'(i - prevIdx), 32'd10);
            prevIdx = i;
            pulses++;
         end
      end
      checkOutput("b2b_pulses", 32'(pulses), 32'd4);
      start8 = 1'b0;
      repeat (12) @(negedge clk);
      checkOutput("final_idle", 32'(ready8), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
